// File: rtl/mips32_prog_loader.sv
// Program loader / run controller for a small MIPS32 core.
// Streams a program into instruction memory, pulses the core start, waits
// for HALTED (bounded by a timeout) and then streams out the low registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the first program word, word count at 0
// S_LOAD  | accepting program words, one memory write per word
// S_START | single-cycle cpu_start pulse
// S_RUN   | core running; HALTED ignored on the first cycle, timeout armed
// S_DUMP  | reading registers R0.. and presenting them on the out stream
// S_DONE  | finished, done held until reset

module mips32_prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int DUMP_COUNT  = 6,
    parameter int RUN_TIMEOUT = 1023
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_start,
    input  logic              cpu_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              out_valid,
    output logic              out_last,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_timeout
);

    // Run timer is a down-counter loaded with RUN_TIMEOUT-1; terminal count 0
    // is reached on the RUN_TIMEOUT-th RUN cycle.
    localparam int RW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [RW-1:0]     RUN_LOAD = RW'(RUN_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [4:0]        IDX_LAST = 5'(DUMP_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wcnt;
    logic [RW-1:0]     run_cnt;
    logic              run_first;
    logic [4:0]        idx;
    logic              accept;

    assign accept    = in_valid && in_ready;
    // The dump index register drives the register-file address directly.
    assign reg_raddr = idx;

    // Sequencer: all outputs are registered and decided alongside the next state.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            run_cnt     <= '0;
            run_first   <= 1'b0;
            idx         <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wcnt;
                        mem_wdata <= in_data;
                        busy      <= 1'b1;
                        // A full memory ends the load early rather than wrapping.
                        if (in_last || (wcnt == ADDR_MAX)) begin
                            if (!in_last) begin
                                err_ovf <= 1'b1;
                            end
                            state     <= S_START;
                            in_ready  <= 1'b0;
                            cpu_start <= 1'b1;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    state     <= S_RUN;
                    run_cnt   <= RUN_LOAD;
                    run_first <= 1'b1;
                end
                S_RUN: begin
                    run_first <= 1'b0;
                    // HALTED may still be stale from the previous run on the
                    // first cycle, so it only counts from the second cycle on.
                    // A halt seen on the terminal cycle wins over the timeout.
                    if (!run_first && cpu_halted) begin
                        state <= S_DUMP;
                        idx   <= '0;
                    end else if (run_cnt == '0) begin
                        err_timeout <= 1'b1;
                        state       <= S_DUMP;
                        idx         <= '0;
                    end else begin
                        run_cnt <= run_cnt - 1'b1;
                    end
                end
                S_DUMP: begin
                    if (!out_valid) begin
                        out_data  <= reg_rdata;
                        out_valid <= 1'b1;
                        out_last  <= (idx == IDX_LAST);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: two instances (default geometry, and a tiny
// 4-word memory with a 20-cycle timeout) share stimulus; sel picks the live
// one and holds the other in reset. A small instruction-level model of the
// core produces the register contents that the dump must return.

module tb_mips32_prog_loader;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n, sel;
    logic        in_valid, in_last, out_ready, cpu_halted;
    logic [31:0] in_data, reg_rdata;
    logic        rst_a, rst_b;

    logic        a_in_ready, a_mem_we, a_cpu_start, a_out_valid, a_out_last;
    logic        a_busy, a_done, a_err_ovf, a_err_timeout;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_out_data;
    logic [4:0]  a_reg_raddr;
    logic        b_in_ready, b_mem_we, b_cpu_start, b_out_valid, b_out_last;
    logic        b_busy, b_done, b_err_ovf, b_err_timeout;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_out_data;
    logic [4:0]  b_reg_raddr;

    logic        in_ready, mem_we, cpu_start, out_valid, out_last;
    logic        busy, done, err_ovf, err_timeout;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, out_data;
    logic [4:0]  reg_raddr;

    assign rst_a = rst_n && !sel;
    assign rst_b = rst_n && sel;

    mips32_prog_loader #(.ADDR_W(10), .DUMP_COUNT(6), .RUN_TIMEOUT(1023)) dut_a (
        .clk1(clk1), .rst_n(rst_a), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(a_in_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .cpu_start(a_cpu_start),
        .cpu_halted(cpu_halted), .reg_raddr(a_reg_raddr), .reg_rdata(reg_rdata),
        .out_valid(a_out_valid), .out_last(a_out_last), .out_data(a_out_data),
        .out_ready(out_ready), .busy(a_busy), .done(a_done),
        .err_ovf(a_err_ovf), .err_timeout(a_err_timeout));

    mips32_prog_loader #(.ADDR_W(2), .DUMP_COUNT(6), .RUN_TIMEOUT(20)) dut_b (
        .clk1(clk1), .rst_n(rst_b), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(b_in_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_start(b_cpu_start),
        .cpu_halted(cpu_halted), .reg_raddr(b_reg_raddr), .reg_rdata(reg_rdata),
        .out_valid(b_out_valid), .out_last(b_out_last), .out_data(b_out_data),
        .out_ready(out_ready), .busy(b_busy), .done(b_done),
        .err_ovf(b_err_ovf), .err_timeout(b_err_timeout));

    assign in_ready    = sel ? b_in_ready    : a_in_ready;
    assign mem_we      = sel ? b_mem_we      : a_mem_we;
    assign mem_addr    = sel ? {8'd0, b_mem_addr} : a_mem_addr;
    assign mem_wdata   = sel ? b_mem_wdata   : a_mem_wdata;
    assign cpu_start   = sel ? b_cpu_start   : a_cpu_start;
    assign reg_raddr   = sel ? b_reg_raddr   : a_reg_raddr;
    assign out_valid   = sel ? b_out_valid   : a_out_valid;
    assign out_last    = sel ? b_out_last    : a_out_last;
    assign out_data    = sel ? b_out_data    : a_out_data;
    assign busy        = sel ? b_busy        : a_busy;
    assign done        = sel ? b_done        : a_done;
    assign err_ovf     = sel ? b_err_ovf     : a_err_ovf;
    assign err_timeout = sel ? b_err_timeout : a_err_timeout;

    logic [31:0] regs [32];
    assign reg_rdata = regs[reg_raddr];

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] dump;
    } vec_t;
    vec_t tbl [9];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prog  [64];
    logic [31:0] mregs [32];
    logic [31:0] exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [31:0] exp_dd [$];
    logic        exp_dl [$];
    int          start_cnt = 0;
    int          dump_hs   = 0;
    logic        exp_ovf, exp_to;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Passive checker: memory writes, dump handshakes, stream stability.
    initial begin
        logic        pv, pr, pl;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk1);
            if (!rst_n) begin
                start_cnt = 0;
                dump_hs   = 0;
                pv        = 1'b0;
                exp_wa.delete(); exp_wd.delete();
                exp_dd.delete(); exp_dl.delete();
            end else begin
                if (mem_we) begin
                    if (exp_wa.size() == 0) begin
                        chk("unexpected_write", 32'(mem_we), 32'd0);
                    end else begin
                        chk("wr_addr", 32'(mem_addr), exp_wa.pop_front());
                        chk("wr_data", mem_wdata, exp_wd.pop_front());
                    end
                end
                if (cpu_start) start_cnt++;
                if (pv && !pr) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", out_data, pd);
                    chk("hold_last", 32'(out_last), 32'(pl));
                end
                if (out_valid && out_ready) begin
                    if (exp_dd.size() == 0) begin
                        chk("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        chk("dump_data", out_data, exp_dd.pop_front());
                        chk("dump_last", 32'(out_last), 32'(exp_dl.pop_front()));
                    end
                    dump_hs++;
                end
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            end
        end
    end

    // Reference: which words land where, what the core computes from them.
    task automatic prepare_model(input int n, input int cap);
        int          acc;
        logic [31:0] w, imm;
        int          rs, rt, rd;
        acc     = (n < cap) ? n : cap;
        exp_ovf = (n > cap);
        for (int i = 0; i < acc; i++) begin
            exp_wa.push_back(32'(i));
            exp_wd.push_back(prog[i]);
        end
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        for (int pc = 0; pc < acc; pc++) begin
            w   = prog[pc];
            rs  = int'(w[25:21]);
            rt  = int'(w[20:16]);
            rd  = int'(w[15:11]);
            imm = {{16{w[15]}}, w[15:0]};
            if (w[31:26] == 6'h3f) break;
            case (w[31:26])
                6'h00:   mregs[rd] = mregs[rs] + mregs[rt];
                6'h03:   mregs[rd] = mregs[rs] | mregs[rt];
                6'h0a:   mregs[rt] = mregs[rs] + imm;
                default: ;
            endcase
            mregs[0] = '0;
        end
        for (int i = 0; i < 6; i++) begin
            exp_dd.push_back(mregs[i]);
            exp_dl.push_back(i == 5);
        end
    endtask

    task automatic stream_words(input int n, input int cap, input int gap_max, input bit last_end);
        bit acc;
        int cyc;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
            in_valid = 1'b1;
            in_data  = prog[i];
            in_last  = last_end && (i == n - 1);
            if (i >= cap) begin
                repeat (6) begin
                    tick();
                    chk("no_accept_full", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                break;
            end
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                acc = in_ready;
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            if (!acc) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_last = 1'b0;
    endtask

    // Core stand-in: loads its registers at start, raises HALTED in RUN cycle
    // halt_k (0 = already high from before), measures start-to-first-word.
    task automatic halt_drv(input int halt_k, input int exp_run);
        int cyc, c;
        cyc = 0;
        while (!cpu_start && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("start_pulse", 32'(cpu_start), 32'd1);
        chk("busy_in_start", 32'(busy), 32'd1);
        for (int r = 0; r < 32; r++) regs[r] = mregs[r];
        c = 0;
        while (!out_valid && c < 3000) begin
            tick();
            c++;
            if (c == halt_k) cpu_halted = 1'b1;
        end
        chk("run_latency", 32'(c), 32'(exp_run + 2));
        chk("start_single", 32'(start_cnt), 32'd1);
    endtask

    task automatic phase1(input int n, input int cap, input int rt, input int gap_max,
                          input bit last_end, input int halt_k);
        int er;
        if (halt_k == 0)       er = 2;
        else if (halt_k <= rt) er = (halt_k < 2) ? 2 : halt_k;
        else                   er = rt;
        exp_to     = (halt_k > rt);
        cpu_halted = (halt_k == 0);
        out_ready  = 1'b0;
        fork
            stream_words(n, cap, gap_max, last_end);
            halt_drv(halt_k, er);
        join
    endtask

    task automatic phase2(input int bp_mode);
        int cyc, hold;
        cyc  = 0;
        hold = 0;
        while (!done && cyc < 1000) begin
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (dump_hs == 1 && out_valid && hold < 3) begin
                        out_ready = 1'b0;
                        chk("bp_word1", out_data, tbl[1].dump);
                        hold++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            tick();
            cyc++;
        end
        if (bp_mode == 2) chk("bp_hold_cycles", 32'(hold), 32'd3);
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("words_dumped", 32'(dump_hs), 32'd6);
        chk("writes_left", 32'(exp_wa.size()), 32'd0);
        chk("dump_left", 32'(exp_dd.size()), 32'd0);
        chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
        chk("err_timeout", 32'(err_timeout), 32'(exp_to));
        out_ready = 1'b0;
        repeat (3) tick();
        chk("done_hold", 32'(done), 32'd1);
        chk("no_valid_after_done", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset(input logic s);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        cpu_halted = 1'b0;
        tick();
        sel = s;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_reg_raddr", 32'(reg_raddr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    endtask

    task automatic load_table();
        for (int i = 0; i < 9; i++) prog[i] = tbl[i].data;
    endtask

    task automatic run_body(input logic s, input int n, input int gap_max, input bit last_end,
                            input int halt_k, input int bp_mode, input bit use_tbl);
        int cap, rt;
        cap = s ? 4 : 1024;
        rt  = s ? 20 : 1023;
        prepare_model(n, cap);
        if (use_tbl) begin
            exp_dd.delete();
            for (int i = 0; i < 6; i++) exp_dd.push_back(tbl[i].dump);
        end
        phase1(n, cap, rt, gap_max, last_end, halt_k);
        phase2(bp_mode);
    endtask

    function automatic logic [31:0] rand_instr();
        if ($urandom_range(0, 2) == 0)
            return {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(1, 7)), 11'd0};
        return {6'h0a, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 16'($urandom)};
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h2801000a, 1'b0, 32'd0};
        tbl[1] = '{32'h28020014, 1'b0, 32'd10};
        tbl[2] = '{32'h28030019, 1'b0, 32'd20};
        tbl[3] = '{32'h0ce77800, 1'b0, 32'd25};
        tbl[4] = '{32'h0ce77800, 1'b0, 32'd30};
        tbl[5] = '{32'h00222000, 1'b0, 32'd55};
        tbl[6] = '{32'h0ce77800, 1'b0, 32'd0};
        tbl[7] = '{32'h00832800, 1'b0, 32'd0};
        tbl[8] = '{32'hfc000000, 1'b1, 32'd0};
        for (int r = 0; r < 32; r++) regs[r] = '0;
        sel = 1'b0; rst_n = 1'b0; in_data = '0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; cpu_halted = 1'b0;

        // Reset values.
        tick();
        tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Reference program: back-to-back, then with gaps and a held second word.
        load_table();
        run_body(1'b0, 9, 0, 1'b1, 5, 0, 1'b1);
        do_reset(1'b0);
        load_table();
        run_body(1'b0, 9, 2, 1'b1, 3, 2, 1'b1);

        // HALTED left high from the previous run.
        do_reset(1'b0);
        load_table();
        run_body(1'b0, 9, 0, 1'b1, 0, 0, 1'b1);

        // Timeout with HALTED never raised, then halt exactly on the last cycle.
        do_reset(1'b1);
        prog[0] = 32'h28010007; prog[1] = 32'h28220003; prog[2] = 32'hfc000000;
        run_body(1'b1, 3, 0, 1'b1, 100, 1, 1'b0);
        do_reset(1'b1);
        run_body(1'b1, 3, 1, 1'b1, 20, 0, 1'b0);
        do_reset(1'b1);
        run_body(1'b1, 3, 0, 1'b1, 21, 0, 1'b0);

        // Overflow of the 4-word memory with last never set.
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) prog[i] = {6'h0a, 5'd0, 5'(i + 1), 16'(i * 3 + 1)};
        run_body(1'b1, 5, 1, 1'b0, 4, 1, 1'b0);

        // Exactly filling the memory with last on the final word is not an overflow.
        do_reset(1'b1);
        run_body(1'b1, 4, 0, 1'b1, 6, 0, 1'b0);

        // Reset after 3 of 9 words, then reload from address 0.
        do_reset(1'b0);
        load_table();
        prepare_model(9, 1024);
        stream_words(3, 1024, 1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();
        run_body(1'b0, 9, 1, 1'b1, 4, 1, 1'b1);

        // Reset while the first dump word is waiting.
        do_reset(1'b0);
        load_table();
        prepare_model(9, 1024);
        phase1(9, 1024, 1023, 0, 1'b1, 4);
        chk("dump_pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("no_valid_after_abort", 32'(out_valid), 32'd0);
        chk("idle_after_abort", 32'(in_ready), 32'd1);

        // Randomised programs, gaps, halt timing and back-pressure.
        for (int it = 0; it < 24; it++) begin
            logic s;
            int   n;
            s = 1'(it % 2);
            n = s ? $urandom_range(2, 6) : $urandom_range(2, 14);
            for (int j = 0; j < n - 1; j++) prog[j] = rand_instr();
            prog[n - 1] = 32'hfc000000;
            do_reset(s);
            run_body(s, n, $urandom_range(0, 3), 1'b1,
                     $urandom_range(0, s ? 25 : 40), 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
